// File: rtl/stepper_scan_sequencer.sv
// Autonomous rangefinder scan engine. The CPU configures it through an Avalon-MM
// slave. It then drives stepper_controller as an Avalon-MM master. For each point
// it makes one limited move, dwells, triggers a measurement and waits for it.
module stepper_scan_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000000,
  parameter logic [31:0] DIV_RESET      = 32'd100000
) (
  input  logic        avs_clk,
  input  logic        avs_reset,
  input  logic        avs_cs,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avm_cs,
  output logic [1:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        meas_trigger,
  input  logic        meas_done,
  output logic        scan_irq
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_DIV, ST_WR_DIST, ST_RD_POS, ST_CAP_POS, ST_WR_START, ST_POLL_RD,
    ST_POLL_CHK, ST_DWELL, ST_TRIG, ST_WAIT_MEAS, ST_NEXT, ST_ABORT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] speed_reg, step_dist_reg, num_points_reg, dwell_reg;
  logic [31:0] point_cnt_reg, last_pos_reg, target_reg, timeout_cnt_reg, dwell_cnt_reg;
  logic        dir_reg, busy_reg, done_reg, error_reg;
  logic        start_scan, set_done, set_error;
  logic [31:0] rd_mux;

  logic        wr_en, ctrl_wr, status_wr, start_req, abort_req, poll_match, timeout_hit;
  logic        polling_now, polling_next;
  logic [31:0] point_cnt_inc;

  assign wr_en         = avs_cs & avs_write;
  assign ctrl_wr       = wr_en & (avs_address == 3'd0);
  assign status_wr     = wr_en & (avs_address == 3'd1);
  assign start_req     = ctrl_wr & avs_writedata[0];
  assign abort_req     = ctrl_wr & ~avs_writedata[0] &
                         (state_reg != ST_IDLE) & (state_reg != ST_ABORT);
  assign poll_match    = (avm_readdata == target_reg);
  assign timeout_hit   = ((timeout_cnt_reg + 32'd1) >= TIMEOUT_CYCLES);
  assign point_cnt_inc = point_cnt_reg + 32'd1;
  assign polling_now   = (state_reg == ST_POLL_RD) | (state_reg == ST_POLL_CHK);
  assign polling_next  = (state_next == ST_POLL_RD) | (state_next == ST_POLL_CHK);
  assign scan_irq      = done_reg | error_reg;

  // State register
  always_ff @(posedge avs_clk or posedge avs_reset) begin
    if (avs_reset) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic; the master access is decoded purely from the current state
  always_comb begin
    state_next    = state_reg;
    avm_cs        = 1'b0;
    avm_address   = 2'd0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_writedata = 32'd0;
    meas_trigger  = 1'b0;
    start_scan    = 1'b0;
    set_done      = 1'b0;
    set_error     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          if (num_points_reg == 32'd0) begin
            set_done = 1'b1;
          end else begin
            start_scan = 1'b1;
            state_next = ST_WR_DIV;
          end
        end
      end
      ST_WR_DIV: begin
        avm_cs = 1'b1; avm_write = 1'b1; avm_address = 2'd2; avm_writedata = speed_reg;
        state_next = ST_WR_DIST;
      end
      ST_WR_DIST: begin
        avm_cs = 1'b1; avm_write = 1'b1; avm_address = 2'd3; avm_writedata = step_dist_reg;
        state_next = ST_RD_POS;
      end
      ST_RD_POS: begin
        avm_cs = 1'b1; avm_read = 1'b1; avm_address = 2'd1;
        state_next = ST_CAP_POS;
      end
      ST_CAP_POS: state_next = ST_WR_START;
      ST_WR_START: begin
        avm_cs = 1'b1; avm_write = 1'b1; avm_address = 2'd0;
        avm_writedata = {29'd0, dir_reg, 1'b1, 1'b1};
        state_next = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        avm_cs = 1'b1; avm_read = 1'b1; avm_address = 2'd1;
        state_next = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (poll_match) begin
          state_next = ST_DWELL;
        end else if (timeout_hit) begin
          set_error  = 1'b1;
          state_next = ST_ABORT;
        end else begin
          state_next = ST_POLL_RD;
        end
      end
      ST_DWELL: if (dwell_cnt_reg >= dwell_reg) state_next = ST_TRIG;
      ST_TRIG: begin
        meas_trigger = 1'b1;
        state_next   = ST_WAIT_MEAS;
      end
      ST_WAIT_MEAS: if (meas_done) state_next = ST_NEXT;
      ST_NEXT: begin
        if (point_cnt_inc == num_points_reg) begin
          set_done   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WR_DIV;
        end
      end
      ST_ABORT: begin
        avm_cs = 1'b1; avm_write = 1'b1; avm_address = 2'd0; avm_writedata = 32'd0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A CPU abort overrides whatever the current state decided this cycle
    if (abort_req) begin
      state_next = ST_ABORT;
      set_done   = 1'b0;
      set_error  = 1'b0;
    end
  end

  // Slave read mux
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      3'd0: rd_mux = {30'd0, dir_reg, busy_reg};
      3'd1: rd_mux = {29'd0, error_reg, done_reg, busy_reg};
      3'd2: rd_mux = speed_reg;
      3'd3: rd_mux = step_dist_reg;
      3'd4: rd_mux = num_points_reg;
      3'd5: rd_mux = dwell_reg;
      3'd6: rd_mux = point_cnt_reg;
      3'd7: rd_mux = last_pos_reg;
      default: rd_mux = 32'd0;
    endcase
  end

  // Configuration, status and scan datapath registers
  always_ff @(posedge avs_clk or posedge avs_reset) begin
    if (avs_reset) begin
      speed_reg       <= DIV_RESET;
      step_dist_reg   <= 32'd0;
      num_points_reg  <= 32'd0;
      dwell_reg       <= 32'd0;
      dir_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      point_cnt_reg   <= 32'd0;
      last_pos_reg    <= 32'd0;
      target_reg      <= 32'd0;
      timeout_cnt_reg <= 32'd0;
      dwell_cnt_reg   <= 32'd0;
      avs_readdata    <= 32'd0;
    end else begin
      busy_reg <= (state_next != ST_IDLE);

      // Setting a sticky flag wins over a simultaneous CPU clear
      if (set_done)                             done_reg <= 1'b1;
      else if (status_wr && avs_writedata[1])   done_reg <= 1'b0;
      if (set_error)                            error_reg <= 1'b1;
      else if (status_wr && avs_writedata[2])   error_reg <= 1'b0;

      // Configuration is frozen for the duration of a scan
      if (wr_en && !busy_reg) begin
        case (avs_address)
          3'd0: dir_reg        <= avs_writedata[1];
          3'd2: speed_reg      <= avs_writedata;
          3'd3: step_dist_reg  <= avs_writedata;
          3'd4: num_points_reg <= avs_writedata;
          3'd5: dwell_reg      <= avs_writedata;
          default: ;
        endcase
      end

      if (start_scan)                               point_cnt_reg <= 32'd0;
      else if (state_reg == ST_NEXT && !abort_req)  point_cnt_reg <= point_cnt_inc;

      // Target wraps modulo 2^32 by construction
      if (state_reg == ST_CAP_POS && !abort_req)
        target_reg <= dir_reg ? (avm_readdata + step_dist_reg) : (avm_readdata - step_dist_reg);

      if (state_reg == ST_POLL_CHK && poll_match && !abort_req)
        last_pos_reg <= avm_readdata;

      if (polling_now && polling_next) timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
      else                             timeout_cnt_reg <= 32'd0;

      if (state_reg == ST_DWELL) dwell_cnt_reg <= dwell_cnt_reg + 32'd1;
      else                       dwell_cnt_reg <= 32'd0;

      if (avs_cs && avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_stepper_scan_sequencer.sv
// Directed bench for stepper_scan_sequencer with a behavioural stepper_controller model.
module tb_stepper_scan_sequencer;

  logic        avs_clk = 1'b0;
  logic        avs_reset = 1'b0;
  logic        avs_cs = 1'b0;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avm_cs;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        meas_trigger;
  logic        meas_done = 1'b0;
  logic        scan_irq;

  int tests = 0;
  int fails = 0;

  always #5 avs_clk = ~avs_clk;

  stepper_scan_sequencer #(.TIMEOUT_CYCLES(32'd100), .DIV_RESET(32'd100000)) dut (
    .avs_clk(avs_clk), .avs_reset(avs_reset), .avs_cs(avs_cs), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avm_cs(avm_cs), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .meas_trigger(meas_trigger), .meas_done(meas_done),
    .scan_irq(scan_irq)
  );

  // Stepper model: one step per cycle for a limited move, plus bus/trigger monitors
  logic [31:0] m_pos = 32'd0, m_dist = 32'd0, m_rem = 32'd0, pos_preset = 32'd0;
  logic        m_dir = 1'b0, m_freeze = 1'b0, pos_load = 1'b0, meas_auto = 1'b1;
  int          md_cnt = 0, trig_count = 0, pos_rd_count = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], trig_pos_q[$];

  always @(posedge avs_clk) begin
    if (avm_cs && avm_read) begin
      avm_readdata <= (avm_address == 2'd1) ? m_pos : 32'd0;
      if (avm_address == 2'd1) pos_rd_count <= pos_rd_count + 1;
    end
    if (pos_load) begin
      m_pos <= pos_preset;
    end else if (avm_cs && avm_write) begin
      wr_addr_q.push_back({30'd0, avm_address});
      wr_data_q.push_back(avm_writedata);
      if (avm_address == 2'd3) m_dist <= avm_writedata;
      if (avm_address == 2'd0) begin
        if (avm_writedata[0]) begin
          m_rem <= m_dist;
          m_dir <= avm_writedata[2];
        end else begin
          m_rem <= 32'd0;
        end
      end
    end else if (m_rem != 32'd0 && !m_freeze) begin
      m_pos <= m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
      m_rem <= m_rem - 32'd1;
    end
    meas_done <= 1'b0;
    if (meas_trigger) begin
      trig_count <= trig_count + 1;
      trig_pos_q.push_back(m_pos);
      if (meas_auto) md_cnt <= 3;
    end else if (md_cnt != 0) begin
      md_cnt <= md_cnt - 1;
      if (md_cnt == 1) meas_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge avs_clk);
    avs_cs = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge avs_clk);
    avs_cs = 1'b0; avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge avs_clk);
    avs_cs = 1'b1; avs_read = 1'b1; avs_address = a;
    @(negedge avs_clk);
    avs_cs = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    avs_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (!scan_irq && n < budget) begin
      @(negedge avs_clk);
      n++;
    end
    check(tag, 32'(scan_irq), 32'd1);
  endtask

  task automatic preset_pos(input logic [31:0] p);
    @(negedge avs_clk);
    pos_preset = p; pos_load = 1'b1;
    @(negedge avs_clk);
    pos_load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, tb, tpb, rb, n;
    logic [31:0] exp_a[3];
    logic [31:0] exp_d[3];

    // Reset state
    #1 avs_reset = 1'b1;
    repeat (3) @(negedge avs_clk);
    avs_reset = 1'b0;
    check("rst_outputs", 32'({avm_cs, avm_write, avm_read, meas_trigger, scan_irq}), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    rd_check("rst_speed", 3'd2, 32'd100000);
    rd_check("rst_status", 3'd1, 32'd0);
    rd_check("rst_point_cnt", 3'd6, 32'd0);

    // Three points forward, start at 0
    avs_wr(3'd2, 32'd10);
    avs_wr(3'd3, 32'd5);
    avs_wr(3'd4, 32'd3);
    avs_wr(3'd5, 32'd4);
    wb = wr_addr_q.size(); tb = trig_count; tpb = trig_pos_q.size();
    avs_wr(3'd0, 32'h3);
    wait_irq("fwd_irq", 2000);
    check("fwd_nwrites", 32'(wr_addr_q.size() - wb), 32'd9);
    exp_a[0] = 32'd2;  exp_a[1] = 32'd3; exp_a[2] = 32'd0;
    exp_d[0] = 32'd10; exp_d[1] = 32'd5; exp_d[2] = 32'h7;
    if (wr_addr_q.size() >= wb + 9) begin
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("fwd_wr_addr_p%0d_%0d", p, k), wr_addr_q[wb + 3*p + k], exp_a[k]);
          check($sformatf("fwd_wr_data_p%0d_%0d", p, k), wr_data_q[wb + 3*p + k], exp_d[k]);
        end
      end
    end
    check("fwd_triggers", 32'(trig_count - tb), 32'd3);
    if (trig_pos_q.size() >= tpb + 3) begin
      for (int p = 0; p < 3; p++)
        check($sformatf("fwd_target_p%0d", p), trig_pos_q[tpb + p], 32'(5 * (p + 1)));
    end
    rd_check("fwd_point_cnt", 3'd6, 32'd3);
    rd_check("fwd_last_pos", 3'd7, 32'd15);
    rd_check("fwd_status", 3'd1, 32'h2);
    avs_wr(3'd1, 32'h2);
    check("fwd_irq_clr", 32'(scan_irq), 32'd0);

    // Reverse with wrap-around below zero
    preset_pos(32'd2);
    avs_wr(3'd4, 32'd1);
    wb = wr_addr_q.size();
    avs_wr(3'd0, 32'h1);
    wait_irq("rev_irq", 500);
    rd_check("rev_last_pos", 3'd7, 32'hFFFF_FFFD);
    if (wr_data_q.size() >= wb + 3) check("rev_start_data", wr_data_q[wb + 2], 32'h3);
    rd_check("rev_status", 3'd1, 32'h2);
    avs_wr(3'd1, 32'h2);

    // Abort in IDLE does nothing
    wb = wr_addr_q.size();
    avs_wr(3'd0, 32'h0);
    repeat (5) @(negedge avs_clk);
    check("idle_abort_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
    rd_check("idle_abort_status", 3'd1, 32'd0);

    // Abort mid-move
    preset_pos(32'd0);
    avs_wr(3'd3, 32'd50);
    avs_wr(3'd4, 32'd2);
    wb = wr_addr_q.size(); tb = trig_count;
    avs_wr(3'd0, 32'h3);
    n = 0;
    while (wr_addr_q.size() < wb + 3 && n < 200) begin
      @(negedge avs_clk);
      n++;
    end
    check("abort_started", 32'(wr_addr_q.size() - wb), 32'd3);
    repeat (5) @(negedge avs_clk);
    avs_wr(3'd0, 32'h0);
    repeat (10) @(negedge avs_clk);
    check("abort_nwr", 32'(wr_addr_q.size() - wb), 32'd4);
    check("abort_stop_addr", wr_addr_q[wr_addr_q.size() - 1], 32'd0);
    check("abort_stop_data", wr_data_q[wr_data_q.size() - 1], 32'd0);
    repeat (200) @(negedge avs_clk);
    check("abort_no_trig", 32'(trig_count - tb), 32'd0);
    check("abort_quiet", 32'(wr_addr_q.size() - wb), 32'd4);
    rd_check("abort_status", 3'd1, 32'd0);

    // Frozen stepper times out
    m_freeze = 1'b1;
    avs_wr(3'd3, 32'd5);
    avs_wr(3'd4, 32'd1);
    wb = wr_addr_q.size();
    avs_wr(3'd0, 32'h3);
    wait_irq("tmo_irq", 1000);
    rd_check("tmo_status", 3'd1, 32'h4);
    check("tmo_nwr", 32'(wr_addr_q.size() - wb), 32'd4);
    check("tmo_stop_addr", wr_addr_q[wr_addr_q.size() - 1], 32'd0);
    check("tmo_stop_data", wr_data_q[wr_data_q.size() - 1], 32'd0);
    avs_wr(3'd1, 32'h4);
    rd_check("tmo_status_clr", 3'd1, 32'd0);
    check("tmo_irq_clr", 32'(scan_irq), 32'd0);
    m_freeze = 1'b0;

    // NUM_POINTS=0 completes without touching the stepper
    avs_wr(3'd4, 32'd0);
    wb = wr_addr_q.size(); rb = pos_rd_count;
    avs_wr(3'd0, 32'h3);
    repeat (5) @(negedge avs_clk);
    rd_check("np0_status", 3'd1, 32'h2);
    check("np0_irq", 32'(scan_irq), 32'd1);
    check("np0_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
    check("np0_nrd", 32'(pos_rd_count - rb), 32'd0);
    avs_wr(3'd1, 32'h2);

    // STEP_DIST=0: one poll per point, triggers still fire
    avs_wr(3'd3, 32'd0);
    avs_wr(3'd4, 32'd2);
    rb = pos_rd_count; tb = trig_count;
    avs_wr(3'd0, 32'h3);
    wait_irq("sd0_irq", 500);
    check("sd0_pos_reads", 32'(pos_rd_count - rb), 32'd4);
    check("sd0_triggers", 32'(trig_count - tb), 32'd2);
    rd_check("sd0_point_cnt", 3'd6, 32'd2);
    avs_wr(3'd1, 32'h2);

    // Reset while waiting for the measurement
    avs_wr(3'd3, 32'd5);
    avs_wr(3'd4, 32'd1);
    meas_auto = 1'b0;
    tb = trig_count;
    avs_wr(3'd0, 32'h3);
    n = 0;
    while (trig_count == tb && n < 500) begin
      @(negedge avs_clk);
      n++;
    end
    check("rstm_trig", 32'(trig_count - tb), 32'd1);
    repeat (3) @(negedge avs_clk);
    #2 avs_reset = 1'b1;
    #1;
    check("rstm_outputs", 32'({avm_cs, avm_write, avm_read, meas_trigger, scan_irq}), 32'd0);
    check("rstm_avm_wdata", avm_writedata, 32'd0);
    check("rstm_avm_addr", 32'(avm_address), 32'd0);
    check("rstm_readdata", avs_readdata, 32'd0);
    @(negedge avs_clk);
    avs_reset = 1'b0;
    wb = wr_addr_q.size(); rb = pos_rd_count;
    repeat (20) @(negedge avs_clk);
    check("rstm_no_wr", 32'(wr_addr_q.size() - wb), 32'd0);
    check("rstm_no_rd", 32'(pos_rd_count - rb), 32'd0);
    rd_check("rstm_speed", 3'd2, 32'd100000);
    rd_check("rstm_step", 3'd3, 32'd0);
    rd_check("rstm_status", 3'd1, 32'd0);
    rd_check("rstm_point_cnt", 3'd6, 32'd0);
    meas_auto = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stepper_scan_sequencer.md
Name: stepper_scan_sequencer

Overview:
- Autonomous scan engine for the rangefinder. It drives the existing stepper controller as an Avalon-MM master through its four registers: control, position, speed divider and distance.
- It performs NUM_POINTS limited moves of STEP_DIST steps each. After each move it dwells, fires a one-cycle measurement trigger and waits for the measurement handshake.
- Configured by the CPU through its own Avalon-MM slave. Sits between the Qsys interconnect and stepper_controller.

Parameters:
- TIMEOUT_CYCLES, 32'd200000000, maximum poll cycles per move before aborting with an error.
- DIV_RESET, 32'd100000, reset value of the SPEED register.

Ports:
- avs_clk  in  1  system clock
- avs_reset  in  1  asynchronous active-high reset
- avs_cs  in  1  slave chip select
- avs_address  in  3  slave register index
- avs_write  in  1  slave write strobe
- avs_writedata  in  32  slave write data
- avs_read  in  1  slave read strobe
- avs_readdata  out  32  slave read data, registered, 1-cycle latency
- avm_cs  out  1  master chip select to stepper_controller
- avm_address  out  2  master register index (0 ctrl, 1 pos, 2 div, 3 dist)
- avm_write  out  1  master write strobe
- avm_writedata  out  32  master write data
- avm_read  out  1  master read strobe
- avm_readdata  in  32  stepper readdata, valid the cycle after avm_read
- meas_trigger  out  1  one-cycle pulse requesting a range measurement
- meas_done  in  1  measurement-complete pulse
- scan_irq  out  1  level interrupt = STATUS.done | STATUS.error

Behaviour:
- Clock and reset: one clock, avs_clk. avs_reset is asynchronous and active-high; it clears all registers and returns the FSM to IDLE.
- Reset values: outputs 0, avs_readdata 0, SPEED=DIV_RESET, other registers 0.
- Slave register map:
  - 0 CTRL: bit0 write-1 = start, write-0 = abort; bit1 dir.
  - 1 STATUS: bit0 busy, bit1 done (sticky), bit2 error (sticky); writing 1 to bit1 or bit2 clears that bit.
  - 2 SPEED.
  - 3 STEP_DIST.
  - 4 NUM_POINTS.
  - 5 DWELL, in clock cycles.
  - 6 POINT_CNT, read-only.
  - 7 LAST_POS, read-only.
- Slave access: reads return the register the next cycle. While busy, writes to 2-5 and CTRL.bit1 are ignored. dir and all configuration are latched at start.
- Master protocol: no waitrequest. Exactly one access per FSM state; avm_cs is asserted with avm_read or avm_write for one cycle and decoded from state. Read data is sampled in the following state.
- FSM states: IDLE, WR_DIV, WR_DIST, RD_POS, CAP_POS, WR_START, POLL_RD, POLL_CHK, DWELL, TRIG, WAIT_MEAS, NEXT, ABORT.
- IDLE:
  - On start with NUM_POINTS=0: set done, stay IDLE.
  - On start with NUM_POINTS>0: clear POINT_CNT, set busy, go to WR_DIV.
- Configuration sequence:
  - WR_DIV writes SPEED to address 2.
  - WR_DIST writes STEP_DIST to address 3.
  - RD_POS reads address 1.
  - CAP_POS computes target = readdata+STEP_DIST if dir=1, else readdata-STEP_DIST. Arithmetic is modulo 2^32, so wrap-around is legal.
  - WR_START writes address 0 with data {29'b0,dir,1'b1,1'b1}.
- Polling:
  - POLL_RD reads address 1.
  - POLL_CHK: if readdata==target, latch LAST_POS, clear the timeout counter and go to DWELL. Otherwise go back to POLL_RD.
  - The timeout counter increments in every POLL_RD/POLL_CHK cycle. Reaching TIMEOUT_CYCLES sets error and goes to ABORT.
- DWELL: counts DWELL cycles; DWELL=0 passes through in one cycle.
- Measurement handshake:
  - TRIG asserts meas_trigger for exactly one cycle.
  - WAIT_MEAS waits for meas_done, sampled starting the cycle after TRIG. A meas_done coinciding with TRIG is ignored. There is no timeout.
- NEXT: POINT_CNT+1.
  - If the count equals NUM_POINTS: clear busy, set done, go to IDLE.
  - Otherwise go to WR_DIV for the next point; base position is re-read each point.
- STEP_DIST=0: the stepper completes immediately, the first poll matches and the scan proceeds normally.
- Abort: a CTRL write with bit0=0 in any non-IDLE state moves to ABORT on the next cycle.
  - ABORT writes address 0 with data 0 (stepper stop), clears busy, goes to IDLE.
  - Any in-flight read data is discarded.
  - An abort write in IDLE has no effect. A start while busy is ignored.
- Simultaneous events: an abort request outranks a poll match, a timeout and meas_done in the same cycle.
- Reset mid-scan: the FSM goes to IDLE immediately and no stop write is issued. The stepper shares the same reset and goes idle on its own.
- The master never writes address 1, so the stepper position is never cleared by this block.

Test Plan:
- SPEED=10, STEP_DIST=5, NUM_POINTS=3, DWELL=4, dir=1, stepper position 0 at start, bench pulses meas_done 3 cycles after each trigger. Expect:
  - write sequence 2/3/0 with data 10, 5, 0x7 per point;
  - targets 5, 10, 15;
  - three meas_trigger pulses;
  - POINT_CNT=3, LAST_POS=15, done=1, scan_irq=1, busy=0.
- dir=0, start position 2, STEP_DIST=5 -> target 0xFFFFFFFD; the scan completes with LAST_POS=0xFFFFFFFD.
- Abort written mid-move -> master writes address 0 with data 0 next, busy=0, done=0, no further triggers.
- Stepper model frozen, TIMEOUT_CYCLES=100 -> error=1, ABORT stop write, scan_irq=1; writing 0x4 to STATUS clears error and scan_irq.
- NUM_POINTS=0 start -> done=1 immediately, no master access. STEP_DIST=0 -> one poll per point, triggers still fire.
- Assert avs_reset during WAIT_MEAS -> all outputs 0, FSM in IDLE, SPEED=DIV_RESET, STATUS=0.
